// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - iterative 32-bit signed multiply/divide unit
//
// Purpose:
//   Multiplies with one shift-add step per cycle and divides with one
//   restoring step per cycle, both on operand magnitudes. The sign is applied
//   at the end. A start is accepted in any state. A start while an operation
//   is running aborts that operation, and the aborted operation gets no
//   done strobe.
//
// Ports:
//   clk             rising-edge clock
//   clr_n           synchronous active-low reset
//   data_operandA   multiplicand / dividend (two's complement)
//   data_operandB   multiplier / divisor (two's complement)
//   ctrl_MULT       start-multiply pulse (wins over ctrl_DIV)
//   ctrl_DIV        start-divide pulse
//   data_result     product low word or quotient, held until next completion
//   data_exception  multiply overflow, divide overflow or divide-by-zero
//   data_resultRDY  one-cycle completion strobe
//   busy            high while a multiply or divide is in flight
//
// Configuration:
//   MULTDIV_DIV0_FAST_EN  when defined, a divide by zero completes after one
//                         step instead of running all 32 steps.

module multdiv_iter (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

`ifdef MULTDIV_DIV0_FAST_EN
  localparam logic FAST_DIV0 = 1'b1;
`else
  localparam logic FAST_DIV0 = 1'b0;
`endif

  logic [1:0]  state;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic        res_sign;

  logic [31:0] in_a_mag;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] mul_add;
  logic [63:0] mul_acc;
  logic [63:0] mul_prod;
  logic        mul_ovf;
  logic [63:0] div_shift;
  logic        div_fits;
  logic [63:0] div_acc;
  logic [31:0] div_quo;
  logic [31:0] div_q;
  logic        b_zero;
  logic        div_ovf;

  // Magnitudes are 32-bit unsigned. The magnitude of 0x80000000 is itself,
  // and it is still correct when read as unsigned.
  assign in_a_mag = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign a_mag    = op_a[31] ? (~op_a + 32'd1) : op_a;
  assign b_mag    = op_b[31] ? (~op_b + 32'd1) : op_b;

  // The multiply accumulator starts at zero and gains |A| << cnt for each set
  // bit of |B|.
  assign mul_add  = b_mag[cnt] ? ({32'd0, a_mag} << cnt) : 64'd0;
  assign mul_acc  = acc + mul_add;
  assign mul_prod = res_sign ? (~mul_acc + 64'd1) : mul_acc;
  assign mul_ovf  = (mul_prod[63:31] != {33{mul_prod[31]}});

  // The divide accumulator holds {remainder, dividend/quotient}. The
  // quotient bits shift in at the LSB as the dividend bits shift out of the
  // top. The remainder is always below |B| <= 2^31, so the shifted
  // remainder still fits in 32 bits.
  assign div_shift = {acc[62:0], 1'b0};
  assign div_fits  = (div_shift[63:32] >= b_mag);
  assign div_acc   = div_fits ? {div_shift[63:32] - b_mag, div_shift[31:0] | 32'd1}
                              : div_shift;
  assign div_quo   = div_acc[31:0];
  assign div_q     = (res_sign && (div_quo != 32'd0)) ? (~div_quo + 32'd1) : div_quo;

  assign b_zero  = (op_b == 32'd0);
  assign div_ovf = (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);

  assign busy = (state == S_MUL) || (state == S_DIV);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state          <= S_IDLE;
      op_a           <= 32'd0;
      op_b           <= 32'd0;
      acc            <= 64'd0;
      cnt            <= 5'd0;
      res_sign       <= 1'b0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        op_a     <= data_operandA;
        op_b     <= data_operandB;
        cnt      <= 5'd0;
        res_sign <= data_operandA[31] ^ data_operandB[31];
        acc      <= ctrl_MULT ? 64'd0 : {32'd0, in_a_mag};
        state    <= ctrl_MULT ? S_MUL : S_DIV;
      end else begin
        case (state)
          S_MUL: begin
            acc <= mul_acc;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state          <= S_DONE;
              data_result    <= mul_prod[31:0];
              data_exception <= mul_ovf;
              data_resultRDY <= 1'b1;
            end
          end
          S_DIV: begin
            if (FAST_DIV0 && b_zero) begin
              state          <= S_DONE;
              data_result    <= 32'd0;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
            end else begin
              acc <= div_acc;
              cnt <= cnt + 5'd1;
              if (cnt == 5'd31) begin
                state          <= S_DONE;
                data_result    <= b_zero ? 32'd0 : (div_ovf ? 32'h8000_0000 : div_q);
                data_exception <= b_zero || div_ovf;
                data_resultRDY <= 1'b1;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
